// File: rtl/shader_ctrl_pkg.sv
// Shared types and field positions for the shader instruction-load sequencer.
// Command byte layout: [7:6] opcode, [5:0] load length - 1, [3:0] register address.
package shader_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_NOP       = 2'b00,
    OP_WRITE_REG = 2'b01,
    OP_LOAD      = 2'b10,
    OP_RSVD      = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REG_DATA = 2'd1,
    ST_LOAD     = 2'd2
  } state_e;

  localparam int unsigned OPC_MSB  = 7;
  localparam int unsigned OPC_LSB  = 6;
  localparam int unsigned ADDR_MSB = 3;
  localparam int unsigned LEN_MSB  = 5;

  // Wide enough for a load count of 64.
  localparam int unsigned CNT_W = 7;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shader_load_ctrl_if.sv
// Bus bundle between the sequencer, the SPI byte receiver, the shader core,
// the instruction memory and the user register bank.
interface shader_load_ctrl_if #(
  parameter int unsigned MEM_DEPTH = 8,
  parameter int unsigned NUM_REGS  = 4
);
  import shader_ctrl_pkg::*;

  localparam int unsigned PTR_W = idx_width(MEM_DEPTH);
  localparam int unsigned RA_W  = idx_width(NUM_REGS);

  logic             cs;
  logic             byte_valid;
  logic [7:0]       rx_byte;
  logic             mode;
  logic             exec_req;
  logic             exec_gnt;
  logic             mem_shift;
  logic             mem_load;
  logic [7:0]       mem_instr;
  logic             reg_wr;
  logic [RA_W-1:0]  reg_addr;
  logic [7:0]       reg_data;
  logic [PTR_W-1:0] ptr;
  logic             busy;
  logic             err;

  modport master (
    input  cs, byte_valid, rx_byte, exec_req,
    output mode, exec_gnt, mem_shift, mem_load, mem_instr,
           reg_wr, reg_addr, reg_data, ptr, busy, err
  );

  modport slave (
    output cs, byte_valid, rx_byte, exec_req,
    input  mode, exec_gnt, mem_shift, mem_load, mem_instr,
           reg_wr, reg_addr, reg_data, ptr, busy, err
  );

endinterface

// File: rtl/shader_mem_arbiter.sv
// Shift-port arbiter: an SPI load byte always wins over a core rotation request.
// Grant/shift strobes and the rotation pointer are registered here.
module shader_mem_arbiter
  import shader_ctrl_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            load_req,
  input  logic [7:0]                      load_byte,
  input  logic                            exec_req,
  input  logic                            exec_allow,
  output logic                            exec_gnt,
  output logic                            mem_shift,
  output logic                            mem_load,
  output logic [7:0]                      mem_instr,
  output logic [idx_width(MEM_DEPTH)-1:0] ptr
);

  localparam int unsigned PTR_W = idx_width(MEM_DEPTH);

  logic load_sel;
  logic exec_sel;

  always_comb begin
    load_sel = load_req;
    exec_sel = exec_req & exec_allow & ~load_req;
  end

  // MEM_DEPTH is a power of two, so the pointer wraps on its own.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exec_gnt  <= 1'b0;
      mem_shift <= 1'b0;
      mem_load  <= 1'b0;
      mem_instr <= 8'h00;
      ptr       <= '0;
    end else begin
      exec_gnt  <= exec_sel;
      mem_shift <= load_sel | exec_sel;
      mem_load  <= load_sel;
      if (load_sel) mem_instr <= load_byte;
      if (load_sel | exec_sel) ptr <= ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/shader_load_ctrl.sv
// Command sequencer between the SPI byte receiver and shader instruction memory.
// Optional sticky error flag: define SHADER_CTRL_ERR_EN; otherwise err is tied low.
//
// state       | meaning
// ST_IDLE     | command mode, decoding opcode bytes, core rotations granted
// ST_REG_DATA | next byte is the data for the latched register address
// ST_LOAD     | data mode, each byte is loaded into memory, core stalled
module shader_load_ctrl
  import shader_ctrl_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 8,
  parameter int unsigned NUM_REGS  = 4
) (
  input logic               clk_i,
  input logic               rst_i,
  shader_load_ctrl_if.master bus
);

  localparam int unsigned     RA_W      = idx_width(NUM_REGS);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(MEM_DEPTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [RA_W-1:0]  addr_q, addr_d;
  logic             addr_bad_q, addr_bad_d;
  logic             mode_q, mode_d;
  logic             reg_wr_q, reg_wr_d;
  logic [RA_W-1:0]  reg_addr_q, reg_addr_d;
  logic [7:0]       reg_data_q, reg_data_d;
  logic             cs_q;
  logic             load_req;

  opcode_e          opcode;
  logic             byte_ok;
  logic             cs_rise;
  logic             new_addr_bad;
  logic [CNT_W-1:0] len_cnt;

  assign opcode       = opcode_e'(bus.rx_byte[OPC_MSB:OPC_LSB]);
  assign byte_ok      = bus.byte_valid & ~bus.cs;
  assign cs_rise      = bus.cs & ~cs_q;
  assign new_addr_bad = ({1'b0, bus.rx_byte[ADDR_MSB:0]} >= 5'(NUM_REGS));
  assign len_cnt      = CNT_W'(bus.rx_byte[LEN_MSB:0]) + CNT_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      addr_q     <= '0;
      addr_bad_q <= 1'b0;
      mode_q     <= 1'b0;
      reg_wr_q   <= 1'b0;
      reg_addr_q <= '0;
      reg_data_q <= 8'h00;
      cs_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      addr_q     <= addr_d;
      addr_bad_q <= addr_bad_d;
      mode_q     <= mode_d;
      reg_wr_q   <= reg_wr_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
      cs_q       <= bus.cs;
    end
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    addr_d     = addr_q;
    addr_bad_d = addr_bad_q;
    mode_d     = mode_q;
    reg_wr_d   = 1'b0;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    load_req   = 1'b0;

    if (cs_rise && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      mode_d  = 1'b0;
    end else if (byte_ok) begin
      unique case (state_q)
        ST_IDLE: begin
          unique case (opcode)
            OP_WRITE_REG: begin
              addr_d     = bus.rx_byte[RA_W-1:0];
              addr_bad_d = new_addr_bad;
              state_d    = ST_REG_DATA;
            end
            OP_LOAD: begin
              rem_d   = (len_cnt > DEPTH_CNT) ? DEPTH_CNT : len_cnt;
              mode_d  = 1'b1;
              state_d = ST_LOAD;
            end
            default: ;
          endcase
        end
        ST_REG_DATA: begin
          if (!addr_bad_q) begin
            reg_wr_d   = 1'b1;
            reg_addr_d = addr_q;
            reg_data_d = bus.rx_byte;
          end
          state_d = ST_IDLE;
        end
        ST_LOAD: begin
          load_req = 1'b1;
          rem_d    = rem_q - CNT_W'(1);
          // Leave data mode together with the final load pulse.
          if (rem_q == CNT_W'(1)) begin
            mode_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.mode     = mode_q;
  assign bus.reg_wr   = reg_wr_q;
  assign bus.reg_addr = reg_addr_q;
  assign bus.reg_data = reg_data_q;
  assign bus.busy     = (state_q != ST_IDLE);

  shader_mem_arbiter #(.MEM_DEPTH(MEM_DEPTH)) u_arb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_req   (load_req),
    .load_byte  (bus.rx_byte),
    .exec_req   (bus.exec_req),
    .exec_allow (state_q != ST_LOAD),
    .exec_gnt   (bus.exec_gnt),
    .mem_shift  (bus.mem_shift),
    .mem_load   (bus.mem_load),
    .mem_instr  (bus.mem_instr),
    .ptr        (bus.ptr)
  );

`ifdef SHADER_CTRL_ERR_EN
  logic err_q;
  logic err_set;

  always_comb begin
    err_set = 1'b0;
    if ((state_q == ST_LOAD) && cs_rise && (rem_q != '0)) err_set = 1'b1;
    if ((state_q == ST_IDLE) && byte_ok &&
        ((opcode == OP_RSVD) || ((opcode == OP_WRITE_REG) && new_addr_bad)))
      err_set = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_shader_load_ctrl.sv
// Scoreboard bench for shader_load_ctrl: a command-level model predicts register
// writes, load bytes, mode/busy/err and grants; a negedge monitor compares.
module tb_shader_load_ctrl;

  localparam int DEPTH = 8;
  localparam int NREGS = 4;
`ifdef SHADER_CTRL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shader_load_ctrl_if #(.MEM_DEPTH(DEPTH), .NUM_REGS(NREGS)) bus ();

  shader_load_ctrl #(.MEM_DEPTH(DEPTH), .NUM_REGS(NREGS)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Command-level reference model
  typedef struct {
    bit is_reg;
    int addr;
    int data;
  } exp_t;

  exp_t sb[$];
  int   m_state;   // 0 idle, 1 awaiting register data, 2 loading
  int   m_left;
  int   m_addr;    // -1 when the latched address is out of range
  bit   m_mode;
  bit   m_err;
  bit   m_cs_prev;

  task automatic model_reset();
    m_state = 0; m_left = 0; m_addr = 0; m_mode = 0; m_err = 0;
    sb.delete();
  endtask

  task automatic model_byte(input int b);
    int op;
    op = (b >> 6) & 3;
    case (m_state)
      0: begin
        if (op == 1) begin
          m_state = 1;
          m_addr  = b & 15;
          if (m_addr >= NREGS) begin m_addr = -1; m_err = 1; end
        end else if (op == 2) begin
          m_left = (b & 63) + 1;
          if (m_left > DEPTH) m_left = DEPTH;
          m_state = 2;
          m_mode  = 1;
        end else if (op == 3) begin
          m_err = 1;
        end
      end
      1: begin
        if (m_addr >= 0) sb.push_back('{1'b1, m_addr, b});
        m_state = 0;
      end
      default: begin
        sb.push_back('{1'b0, 0, b});
        m_left--;
        if (m_left == 0) begin m_state = 0; m_mode = 0; end
      end
    endcase
  endtask

  task automatic model_abort();
    if (m_state != 0) begin
      if (m_state == 2 && m_left > 0) m_err = 1;
      m_state = 0;
      m_mode  = 0;
    end
  endtask

  // One clock of stimulus; the model sees exactly what the DUT will sample.
  task automatic drive(input bit v, input int b, input bit cs, input bit req);
    @(posedge clk); #1;
    bus.byte_valid = v;
    bus.rx_byte    = 8'(b);
    bus.cs         = cs;
    bus.exec_req   = req;
    if (cs && !m_cs_prev) model_abort();
    m_cs_prev = cs;
    if (v && !cs) model_byte(b & 255);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.byte_valid = 1'b0; bus.rx_byte = 8'h00; bus.cs = 1'b0; bus.exec_req = 1'b0;
    m_cs_prev = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mode", bus.mode, 0);
    chk("rst_gnt", bus.exec_gnt, 0);
    chk("rst_shift", bus.mem_shift, 0);
    chk("rst_load", bus.mem_load, 0);
    chk("rst_instr", bus.mem_instr, 0);
    chk("rst_reg_wr", bus.reg_wr, 0);
    chk("rst_reg_addr", bus.reg_addr, 0);
    chk("rst_reg_data", bus.reg_data, 0);
    chk("rst_ptr", bus.ptr, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor
  int mon_loads, mon_grants, mon_regs;
  bit exp_gnt;
  bit exp_mode_q, exp_busy_q, exp_err_q;

  always @(posedge clk) begin
    exp_mode_q <= m_mode;
    exp_busy_q <= (m_state != 0);
    exp_err_q  <= ERR_EN & m_err;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      mon_loads = 0; mon_grants = 0; mon_regs = 0; exp_gnt = 0;
    end else begin
      chk("mode", bus.mode, exp_mode_q);
      chk("busy", bus.busy, exp_busy_q);
      chk("err", bus.err, exp_err_q);
      chk("exec_gnt", bus.exec_gnt, exp_gnt);
      chk("mem_shift", bus.mem_shift, exp_gnt | bus.mem_load);
      if (bus.reg_wr) begin
        mon_regs++;
        if (sb.size() == 0 || !sb[0].is_reg) begin
          n_checks++; n_errors++;
          $display("FAIL reg_wr: got unexpected write addr %0d data %0h, required no write at %0t",
                   bus.reg_addr, bus.reg_data, $time);
        end else begin
          e = sb.pop_front();
          chk("reg_addr", bus.reg_addr, e.addr);
          chk("reg_data", bus.reg_data, e.data);
        end
      end
      if (bus.mem_load) begin
        mon_loads++;
        if (sb.size() == 0 || sb[0].is_reg) begin
          n_checks++; n_errors++;
          $display("FAIL mem_load: got unexpected load %0h, required none at %0t", bus.mem_instr, $time);
        end else begin
          e = sb.pop_front();
          chk("mem_instr", bus.mem_instr, e.data);
        end
      end
      if (bus.exec_gnt) mon_grants++;
      if (bus.mem_shift) chk("ptr", bus.ptr, (mon_loads + mon_grants) % DEPTH);
      // A grant follows any request seen while not in data mode.
      exp_gnt = bus.exec_req && !bus.mode;
    end
  end

  initial begin
    int r0, g0;
    bit cs_v, v, req;
    int b;
    bus.cs = 1'b0; bus.byte_valid = 1'b0; bus.rx_byte = 8'h00; bus.exec_req = 1'b0;
    m_cs_prev = 1'b0;
    model_reset();
    apply_reset();

    // Register write to address 1
    r0 = mon_regs;
    drive(1, 'h41, 0, 0);
    drive(1, 'hA5, 0, 0);
    repeat (3) drive(0, 0, 0, 0);
    @(negedge clk); #1;
    chk("wr_count", mon_regs - r0, 1);
    chk("wr_busy", bus.busy, 0);
    chk("wr_err", bus.err, 0);

    // Three-byte load with the core requesting throughout, then 5 grants wrap ptr
    drive(1, 'h82, 0, 0);
    drive(1, 'h11, 0, 1);
    drive(1, 'h22, 0, 1);
    drive(1, 'h33, 0, 1);
    g0 = mon_grants;
    repeat (5) drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    @(negedge clk); #1;
    chk("load_grants", mon_grants - g0, 5);
    chk("load_ptr_wrap", bus.ptr, 0);
    chk("load_mode", bus.mode, 0);

    // Abort mid-load via chip-select rise
    drive(1, 'h87, 0, 0);
    drive(1, 'hAA, 0, 0);
    drive(1, 'hBB, 0, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    @(negedge clk); #1;
    chk("abort_mode", bus.mode, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_err", bus.err, ERR_EN);
    chk("abort_ptr", bus.ptr, 2);

    // Reserved opcode, then an out-of-range register address
    apply_reset();
    r0 = mon_regs;
    drive(1, 'hC0, 0, 0);
    drive(1, 'h4F, 0, 0);
    drive(1, 'h00, 0, 0);
    repeat (2) drive(0, 0, 0, 0);
    @(negedge clk); #1;
    chk("bad_wr_count", mon_regs - r0, 0);
    chk("bad_err", bus.err, ERR_EN);
    chk("bad_busy", bus.busy, 0);

    // Reset in the middle of a load
    drive(1, 'h83, 0, 0);
    drive(1, 'h01, 0, 0);
    drive(0, 0, 0, 0);
    apply_reset();

    // Randomized traffic
    cs_v = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!cs_v) cs_v = ($urandom_range(0, 99) < 3);
      else       cs_v = ($urandom_range(0, 1) == 0);
      v   = ($urandom_range(0, 99) < 60);
      req = ($urandom_range(0, 1) == 1);
      b   = $urandom_range(0, 255);
      if (m_state == 0 && $urandom_range(0, 1) == 1)
        b = 'h40 | $urandom_range(0, 5);
      drive(v, b, cs_v, req);
    end
    repeat (4) drive(0, 0, 0, 0);
    @(negedge clk); #1;
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
